// File: rtl/ahb_spi_pkg.sv
// Shared definitions for the AHB-Lite SPI master: register offsets,
// AHB transfer-type encodings and the shift engine state encoding.
package ahb_spi_pkg;

  localparam logic [1:0] REG_TX   = 2'd0;
  localparam logic [1:0] REG_RX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode 0, MSB-first, 8-bit SPI shift engine: divider, shift register,
// transfer FSM and pin drivers. Pulses done for one cycle in DONE.
module spi_shift_engine
  import ahb_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data
);

  spi_state_t state;
  spi_state_t state_next;
  logic [7:0] cnt;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic       tick;
  logic       rise;
  logic       fall;

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign rx_data = shreg;

  // State register for the transfer FSM.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus SCK edge detection from the half-period divider.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        tick = (cnt == div);
        rise = tick & ~sck;
        fall = tick & sck;
        if (fall && (bitcnt == 4'd8)) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Divider, shift register and pin drivers; MISO is sampled on the SCK rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck    <= 1'b0;
      mosi   <= 1'b0;
      cs_n   <= 1'b1;
      cnt    <= 8'd0;
      bitcnt <= 4'd0;
      shreg  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg  <= data;
            bitcnt <= 4'd0;
            cnt    <= 8'd0;
            cs_n   <= 1'b0;
            mosi   <= data[7];
            sck    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (tick) cnt <= 8'd0;
          else      cnt <= cnt + 8'd1;
          if (rise) begin
            sck    <= 1'b1;
            shreg  <= {shreg[6:0], miso};
            bitcnt <= bitcnt + 4'd1;
          end
          if (fall) begin
            sck <= 1'b0;
            if (bitcnt != 4'd8) mosi <= shreg[7];
          end
        end
        ST_DONE: begin
          cs_n <= 1'b1;
          sck  <= 1'b0;
        end
        default: begin
          cs_n <= 1'b1;
          sck  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_spi_master.sv
// AHB-Lite responder exposing TXDATA/RXDATA/STATUS/CTRL registers that
// drive an 8-bit mode 0 SPI master. Zero wait states, always OKAY.
module ahb_spi_master
  import ahb_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd4,
  parameter logic [3:0] BASE_MASK = 4'hC
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N
);

  logic [3:0] addr_masked;
  logic [1:0] addr_sel;
  logic       addr_valid;
  logic [1:0] addr_q;
  logic       write_q;
  logic       valid_q;
  logic [7:0] div;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       busy;
  logic       done;
  logic [7:0] eng_rx;
  logic       start;
  logic       wr_ctrl;
  logic       rd_rx;
  logic       rd_stat;
  logic       unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign addr_masked = HADDR[3:0] & BASE_MASK;
  assign addr_sel    = addr_masked[3:2];
  assign addr_valid  = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign start       = valid_q &  write_q & (addr_q == REG_TX);
  assign wr_ctrl     = valid_q &  write_q & (addr_q == REG_CTRL);
  assign rd_rx       = valid_q & ~write_q & (addr_q == REG_RX);
  assign rd_stat     = valid_q & ~write_q & (addr_q == REG_STAT);
  assign unused_bits = ^{HSIZE, HADDR[31:4], addr_masked[1:0], HWDATA[31:8]};

  // Capture the address phase so the data phase can complete the access.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_sel;
      write_q <= HWRITE;
      valid_q <= addr_valid;
    end
  end

  // Read data is decoded in the address phase and presented in the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA <= 32'd0;
    end else if (addr_valid && !HWRITE) begin
      case (addr_sel)
        REG_RX:   HRDATA <= {24'd0, rx_data};
        REG_STAT: HRDATA <= {29'd0, overrun, rx_valid, busy};
        REG_CTRL: HRDATA <= {24'd0, div};
        default:  HRDATA <= 32'd0;
      endcase
    end else begin
      HRDATA <= 32'd0;
    end
  end

  // Register file; a completing transfer wins over a same-cycle read clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      div      <= DIV_RESET;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_ctrl && !busy) div <= HWDATA[7:0];
      if (done) rx_data <= eng_rx;
      if (done)       rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;
      if (done && rx_valid && !rd_rx) overrun <= 1'b1;
      else if (rd_stat)               overrun <= 1'b0;
    end
  end

  spi_shift_engine u_engine (
    .clk     (HCLK),
    .reset   (HRESET),
    .start   (start),
    .data    (HWDATA[7:0]),
    .div     (div),
    .miso    (SPI_MISO),
    .sck     (SPI_SCK),
    .mosi    (SPI_MOSI),
    .cs_n    (SPI_CS_N),
    .busy    (busy),
    .done    (done),
    .rx_data (eng_rx)
  );

endmodule
